id_ex_pipe: RTL and testbench
=============================

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width of register operands, immediate and PC.
REQ-002 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-003 SHALL have ports: clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: id_valid  in  1  decode stage holds a real instruction.
REQ-006 SHALL have ports: id_branch, id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_alu_src  in  1 each  decoded control bits.
REQ-007 SHALL have ports: id_alu_op  in  2  decoded ALU class (00 add, 01 branch compare, 10 R-format).
REQ-008 SHALL have ports: id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decode operands.
REQ-009 SHALL have ports: id_rs1, id_rs2, id_rd  in  5 each  register indices; id_funct  in  4  {instr[30], funct3}.
REQ-010 SHALL have ports: ex_stall  in  1  hold request from execute; flush  in  1  kill request (taken branch).
REQ-011 SHALL have ports: ex_* outputs  out  mirror widths of every id_* input except id_valid, plus ex_valid  out  1.
REQ-012 SHALL have ports: hazard_stall  out  1  combinational load-use stall to PC and IF/ID; bubble_cnt  out  CNT_W  bubbles inserted since reset.

Function
REQ-013 SHALL update registers only on rising clk; hazard_stall is the sole combinational output.
REQ-014 SHALL apply per-edge priority: flush > ex_stall > load-use bubble > capture.
REQ-015 SHALL on flush load a bubble: ex_valid=0, all seven control outputs 0, data/index outputs 0.
REQ-016 SHALL on ex_stall (no flush) hold every ex_* output unchanged; bubble_cnt unchanged.
REQ-017 SHALL on capture copy every id_* field to ex_*, ex_valid=id_valid; control outputs forced 0 when id_valid=0.
REQ-018 SHALL define rs2-used as id_alu_src==0 or id_MemWrite==1; rs1 is always used.
REQ-019 SHALL assert hazard_stall when id_valid & ex_valid & ex_MemRead & ex_rd!=0 & (ex_rd==id_rs1 | (rs2-used & ex_rd==id_rs2)) & !flush & !ex_stall.
REQ-020 SHALL on hazard_stall load a bubble (as REQ-015); the next edge then captures normally since ex_MemRead=0, giving exactly one bubble per load-use.
REQ-021 SHALL increment bubble_cnt by 1 on each edge loading a bubble via flush or hazard; saturate at all-ones, never wrap.
REQ-022 SHALL treat x0 as never hazarding: ex_rd==0 never asserts hazard_stall.
REQ-023 SHALL give one-cycle latency: id_* presented before edge N appear on ex_* after edge N.

Reset
REQ-024 SHALL on reset assertion immediately (no clock) clear ex_valid, all control outputs, all data/index outputs and bubble_cnt to 0.
REQ-025 SHALL drive hazard_stall 0 during reset since ex_valid=0; reset mid-stall discards the held instruction.

Configuration
REQ-026 SHALL compile load-use detection only when ID_EX_HAZARD_DETECT_EN is defined; undefined: hazard_stall tied 0, no hazard bubbles, bubble_cnt counts flushes only; REQ-014/015/016/017/021 unchanged.

Structure
REQ-027 SHALL place alu_op encodings (ALUOP_ADD, ALUOP_BRANCH, ALUOP_RTYPE) and the control-bundle struct (seven control bits) in shared package riscv_pkg, reused by control and execute.
REQ-028 SHALL implement detection (REQ-018/019/022) in sub-module load_use_detect, purely combinational, instantiated under the macro.

Verification
REQ-029 SHALL cover: reset mid-run with ex_valid=1 -> all ex_* and bubble_cnt read 0 before next clk edge.
REQ-030 SHALL cover: capture add x3,x1,x2 (alu_op=10, RegWrite=1, rd=3, rs1_data=5, rs2_data=7) -> next cycle ex_rd=3, ex_rs1_data=5, ex_alu_op=10, ex_valid=1.
REQ-031 SHALL cover: ld x5 in EX, then add x6,x5,x1 in ID -> hazard_stall=1 that cycle, bubble next cycle, add captured following cycle, bubble_cnt=1.
REQ-032 SHALL cover: ld x5 in EX, addi x6,x0,x5-index irrelevant with rs2=5 and alu_src=1 -> hazard_stall=0; ld x0 in EX with rs1=0 -> hazard_stall=0.
REQ-033 SHALL cover: ex_stall=1 for 3 cycles with changing id_* -> ex_* constant; flush and ex_stall together -> bubble, bubble_cnt+1.
REQ-034 SHALL cover: CNT_W=2, 5 flushes -> bubble_cnt=3; with macro undefined repeat REQ-031 stimulus -> hazard_stall=0, no bubble.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: ALU class encodings and the control bundle
// carried from decode through execute.
package riscv_pkg;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // An instruction that is not real must not carry any side-effecting control.
  function automatic ctrl_t ctrl_gate(ctrl_t c, logic valid);
    return valid ? c : ctrl_t'('0);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction in ID; x0 never hazards.
module load_use_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_alu_src,
  input  logic       id_mem_write,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       flush,
  input  logic       ex_stall,
  output logic       hazard_stall
);

  logic rs2_used;
  logic rd_match;

  always_comb begin
    // Stores read rs2 even though the ALU takes the immediate.
    rs2_used     = !id_alu_src || id_mem_write;
    rd_match     = (ex_rd == id_rs1) || (rs2_used && (ex_rd == id_rs2));
    hazard_stall = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                   rd_match && !flush && !ex_stall;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with flush, execute-side hold and a saturating bubble
// counter. Load-use bubble insertion exists only when ID_EX_HAZARD_DETECT_EN is defined.
module id_ex_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_alu_src,
  input  logic [1:0]       id_alu_op,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_RegWrite,
  output logic             ex_MemtoReg,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_alu_src,
  output logic [1:0]       ex_alu_op,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      funct;
  } data_t;

  ctrl_t            id_ctrl, ctrl_d, ctrl_q;
  data_t            id_data, data_d, data_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             load_bubble;

`ifdef ID_EX_HAZARD_DETECT_EN
  load_use_detect u_load_use_detect (
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_alu_src   (id_alu_src),
    .id_mem_write (id_MemWrite),
    .ex_valid     (valid_q),
    .ex_mem_read  (ctrl_q.mem_read),
    .ex_rd        (data_q.rd),
    .flush        (flush),
    .ex_stall     (ex_stall),
    .hazard_stall (hazard_stall)
  );
`else
  assign hazard_stall = 1'b0;
`endif

  // hazard_stall is already masked by flush and ex_stall, so this preserves priority.
  assign load_bubble = flush || hazard_stall;

  always_comb begin
    id_ctrl = '{branch:     id_branch,
                reg_write:  id_RegWrite,
                mem_to_reg: id_MemtoReg,
                mem_read:   id_MemRead,
                mem_write:  id_MemWrite,
                alu_src:    id_alu_src,
                alu_op:     id_alu_op};
    id_data = '{pc:       id_pc,
                rs1_data: id_rs1_data,
                rs2_data: id_rs2_data,
                imm:      id_imm,
                rs1:      id_rs1,
                rs2:      id_rs2,
                rd:       id_rd,
                funct:    id_funct};
  end

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (load_bubble) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (!ex_stall) begin
      valid_d = id_valid;
      ctrl_d  = ctrl_gate(id_ctrl, id_valid);
      data_d  = id_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_branch   = ctrl_q.branch;
  assign ex_RegWrite = ctrl_q.reg_write;
  assign ex_MemtoReg = ctrl_q.mem_to_reg;
  assign ex_MemRead  = ctrl_q.mem_read;
  assign ex_MemWrite = ctrl_q.mem_write;
  assign ex_alu_src  = ctrl_q.alu_src;
  assign ex_alu_op   = ctrl_q.alu_op;
  assign ex_pc       = data_q.pc;
  assign ex_rs1_data = data_q.rs1_data;
  assign ex_rs2_data = data_q.rs2_data;
  assign ex_imm      = data_q.imm;
  assign ex_rs1      = data_q.rs1;
  assign ex_rs2      = data_q.rs2;
  assign ex_rd       = data_q.rd;
  assign ex_funct    = data_q.funct;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: a pipeline-level model checked every negedge plus
// directed hand-computed expectations; follows ID_EX_HAZARD_DETECT_EN if defined.
module tb_id_ex_pipe;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HZ_ON = 1'b1;
`else
  localparam bit HZ_ON = 1'b0;
`endif
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  typedef struct packed {
    logic        valid, branch, regw, m2r, mrd, mwr, asrc;
    logic [1:0]  aluop;
    logic [63:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  funct;
  } ins_t;

  logic clk = 1'b0;
  logic reset, flush, ex_stall;
  ins_t cur, m_ex, dut_ex;
  int   m_cnt;
  int   n_cmp = 0;
  int   n_err = 0;

  logic             ex_valid, ex_branch, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_alu_src;
  logic [1:0]       ex_alu_op;
  logic [63:0]      ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [3:0]       ex_funct;
  logic             hazard_stall;
  logic [CNT_W-1:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_pipe #(.XLEN(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(cur.valid),
    .id_branch(cur.branch), .id_RegWrite(cur.regw), .id_MemtoReg(cur.m2r),
    .id_MemRead(cur.mrd), .id_MemWrite(cur.mwr), .id_alu_src(cur.asrc),
    .id_alu_op(cur.aluop), .id_pc(cur.pc), .id_rs1_data(cur.rs1d),
    .id_rs2_data(cur.rs2d), .id_imm(cur.imm), .id_rs1(cur.rs1), .id_rs2(cur.rs2),
    .id_rd(cur.rd), .id_funct(cur.funct), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_RegWrite(ex_RegWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  assign dut_ex = {ex_valid, ex_branch, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite,
                   ex_alu_src, ex_alu_op, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                   ex_rs1, ex_rs2, ex_rd, ex_funct};

  // ---------------- model ----------------
  function automatic bit exp_hazard();
    bit rs2_used;
    rs2_used = !cur.asrc || cur.mwr;
    return HZ_ON && cur.valid && m_ex.valid && m_ex.mrd && (m_ex.rd != 0) &&
           ((m_ex.rd == cur.rs1) || (rs2_used && m_ex.rd == cur.rs2)) &&
           !flush && !ex_stall;
  endfunction

  function automatic ins_t entering(ins_t i);
    ins_t r;
    r = i;
    if (!i.valid) begin
      r.branch = 0; r.regw = 0; r.m2r = 0; r.mrd = 0; r.mwr = 0; r.asrc = 0; r.aluop = 0;
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ex  <= '0;
      m_cnt <= 0;
    end else if (flush || exp_hazard()) begin
      m_ex  <= '0;
      m_cnt <= (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
    end else if (!ex_stall) begin
      m_ex  <= entering(cur);
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if (dut_ex !== m_ex) begin
      n_err++;
      $display("FAIL ex_bundle t=%0t got %h expected %h", $time, dut_ex, m_ex);
    end
    n_cmp++;
    if (hazard_stall !== exp_hazard()) begin
      n_err++;
      $display("FAIL hazard_stall t=%0t got %0b expected %0b", $time, hazard_stall, exp_hazard());
    end
    n_cmp++;
    if (bubble_cnt !== CNT_W'(m_cnt)) begin
      n_err++;
      $display("FAIL bubble_cnt t=%0t got %0d expected %0d", $time, bubble_cnt, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic ins_t mk_r(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [63:0] a, logic [63:0] b);
    ins_t i = '0;
    i.valid = 1; i.regw = 1; i.aluop = 2'b10;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.rs1d = a; i.rs2d = b;
    i.pc = 64'h1000 + 64'(rd) * 4;
    return i;
  endfunction

  function automatic ins_t mk_ld(logic [4:0] rd, logic [4:0] rs1);
    ins_t i = '0;
    i.valid = 1; i.regw = 1; i.m2r = 1; i.mrd = 1; i.asrc = 1;
    i.rd = rd; i.rs1 = rs1; i.imm = 64'd8; i.pc = 64'h2000;
    return i;
  endfunction

  function automatic ins_t mk_i(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic st);
    ins_t i = '0;
    i.valid = 1; i.asrc = 1; i.regw = !st; i.mwr = st;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = 64'd3; i.pc = 64'h3000;
    return i;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    cur = '0; flush = 0; ex_stall = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    mid();
    chk("reset_valid", 64'(ex_valid), 64'd0);
    chk("reset_cnt", 64'(bubble_cnt), 64'd0);
    chk("reset_hazard", 64'(hazard_stall), 64'd0);

    // add x3,x1,x2 with operands 5 and 7
    nxt(); cur = mk_r(5'd3, 5'd1, 5'd2, 64'd5, 64'd7);
    nxt(); cur = '0;
    mid();
    chk("add_rd", 64'(ex_rd), 64'd3);
    chk("add_rs1_data", ex_rs1_data, 64'd5);
    chk("add_alu_op", 64'(ex_alu_op), 64'd2);
    chk("add_valid", 64'(ex_valid), 64'd1);
    chk("add_regwrite", 64'(ex_RegWrite), 64'd1);

    // non-valid instruction: data copied, control forced off
    nxt(); cur = mk_r(5'd9, 5'd4, 5'd4, 64'd1, 64'd2); cur.valid = 0;
    nxt(); cur = '0;
    mid();
    chk("inv_valid", 64'(ex_valid), 64'd0);
    chk("inv_regwrite", 64'(ex_RegWrite), 64'd0);
    chk("inv_rd", 64'(ex_rd), 64'd9);

    // ld x5 then add x6,x5,x1
    nxt(); cur = mk_ld(5'd5, 5'd1);
    nxt(); cur = mk_r(5'd6, 5'd5, 5'd1, 64'd11, 64'd12);
    mid();
    chk("lu_hazard", 64'(hazard_stall), HZ_ON ? 64'd1 : 64'd0);
    nxt();
    mid();
    chk("lu_bubble_valid", 64'(ex_valid), HZ_ON ? 64'd0 : 64'd1);
    chk("lu_hazard_after", 64'(hazard_stall), 64'd0);
    nxt(); cur = '0;
    mid();
    chk("lu_add_rd", 64'(ex_rd), 64'd6);
    chk("lu_add_valid", 64'(ex_valid), 64'd1);
    chk("lu_cnt", 64'(bubble_cnt), HZ_ON ? 64'd1 : 64'd0);

    // cases that must not hazard (and one store that must)
    nxt(); cur = mk_ld(5'd5, 5'd1);
    nxt(); cur = mk_i(5'd6, 5'd0, 5'd5, 1'b0);
    mid();
    chk("rs2_unused", 64'(hazard_stall), 64'd0);
    cur = mk_i(5'd0, 5'd0, 5'd5, 1'b1); #1;
    chk("store_rs2", 64'(hazard_stall), HZ_ON ? 64'd1 : 64'd0);
    cur.valid = 0; #1;
    chk("id_invalid", 64'(hazard_stall), 64'd0);
    cur = mk_r(5'd6, 5'd5, 5'd1, 64'd0, 64'd0); ex_stall = 1; #1;
    chk("stall_masks", 64'(hazard_stall), 64'd0);
    ex_stall = 0; flush = 1; #1;
    chk("flush_masks", 64'(hazard_stall), 64'd0);
    flush = 0; cur = mk_i(5'd6, 5'd0, 5'd5, 1'b0);
    nxt(); cur = mk_ld(5'd0, 5'd1);
    nxt(); cur = mk_r(5'd7, 5'd0, 5'd0, 64'd0, 64'd0);
    mid();
    chk("x0_no_hazard", 64'(hazard_stall), 64'd0);

    // hold for 3 cycles with changing decode inputs
    nxt(); cur = mk_r(5'd10, 5'd8, 5'd9, 64'hAAAA, 64'hBBBB);
    nxt(); ex_stall = 1;
    for (int k = 0; k < 3; k++) begin
      cur = mk_r(5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom),
                 64'($urandom), 64'($urandom));
      cur.mrd = 1'($urandom);
      nxt();
      mid();
      chk("stall_rd", 64'(ex_rd), 64'd10);
      chk("stall_rs1_data", ex_rs1_data, 64'hAAAA);
      chk("stall_cnt", 64'(bubble_cnt), HZ_ON ? 64'd1 : 64'd0);
    end
    flush = 1;
    nxt(); flush = 0; ex_stall = 0; cur = '0;
    mid();
    chk("flush_stall_valid", 64'(ex_valid), 64'd0);
    chk("flush_stall_rd", 64'(ex_rd), 64'd0);
    chk("flush_stall_cnt", 64'(bubble_cnt), HZ_ON ? 64'd2 : 64'd1);

    // saturation of a 2-bit counter
    nxt(); flush = 1;
    repeat (5) nxt();
    flush = 0;
    mid();
    chk("cnt_saturate", 64'(bubble_cnt), 64'd3);

    // asynchronous reset mid-run while held
    nxt(); cur = mk_r(5'd11, 5'd1, 5'd2, 64'd21, 64'd22);
    nxt(); cur = '0; ex_stall = 1;
    mid();
    chk("pre_reset_valid", 64'(ex_valid), 64'd1);
    #2 reset = 1;
    #1;
    chk("arst_valid", 64'(ex_valid), 64'd0);
    chk("arst_rd", 64'(ex_rd), 64'd0);
    chk("arst_rs1_data", ex_rs1_data, 64'd0);
    chk("arst_regwrite", 64'(ex_RegWrite), 64'd0);
    chk("arst_cnt", 64'(bubble_cnt), 64'd0);
    chk("arst_hazard", 64'(hazard_stall), 64'd0);
    nxt(); reset = 0; ex_stall = 0; cur = mk_ld(5'd12, 5'd3);
    nxt(); cur = '0;
    mid();
    chk("post_reset_memread", 64'(ex_MemRead), 64'd1);
    chk("post_reset_rd", 64'(ex_rd), 64'd12);

    nxt();
    mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
